// File: rtl/dmem_pkg.sv
// Shared definitions for the byte-serializing data-memory controller:
// FSM state codes, lane geometry and the list of legal byte-select masks
// (the list is only consulted when DMEM_SEL_CHK_EN is defined).
package dmem_pkg;

    localparam int LANES  = 4;
    localparam int LANE_W = 8;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_ACCESS = 2'd1;
    localparam state_t ST_DONE   = 2'd2;

    // Legal masks: single bytes, aligned halfwords and the full word.
    localparam int N_LEGAL_SEL = 7;
    localparam logic [N_LEGAL_SEL*LANES-1:0] LEGAL_SEL_LIST = {
        4'b0001, 4'b0010, 4'b0100, 4'b1000,
        4'b0011, 4'b1100, 4'b1111
    };

    function automatic logic sel_is_legal(input logic [LANES-1:0] sel);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < N_LEGAL_SEL; i++) begin
            if (LEGAL_SEL_LIST[i*LANES +: LANES] == sel) begin
                ok = 1'b1;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/dmem_byte_ctrl_if.sv
// MEM-stage request/response bundle between the pipeline (master) and the
// data-memory controller (slave).
interface dmem_byte_ctrl_if;
    import dmem_pkg::*;

    logic              mem_ce_i;
    logic              mem_we_i;
    logic [31:0]       mem_addr_i;
    logic [LANES-1:0]  mem_sel_i;
    logic [31:0]       mem_data_i;
    logic [31:0]       mem_data_o;
    logic              stall_o;

    modport master (
        output mem_ce_i, mem_we_i, mem_addr_i, mem_sel_i, mem_data_i,
        input  mem_data_o, stall_o
    );

    modport slave (
        input  mem_ce_i, mem_we_i, mem_addr_i, mem_sel_i, mem_data_i,
        output mem_data_o, stall_o
    );

endinterface

// File: rtl/dmem_next_lane.sv
// Finds the next enabled byte lane in a select mask. With inclusive=1 the
// current lane itself qualifies, which lets the same block pick the first
// lane of a request (current lane 0) as well as step through the rest.
module dmem_next_lane
    import dmem_pkg::*;
(
    input  logic [LANES-1:0] sel,
    input  logic [1:0]       lane,
    input  logic             inclusive,
    output logic [1:0]       next_lane,
    output logic             none_left
);

    // Scan from the top down so the lowest qualifying lane wins.
    always_comb begin
        next_lane = '0;
        none_left = 1'b1;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (sel[i] && ((i > int'(lane)) || (inclusive && (i == int'(lane))))) begin
                next_lane = 2'(i);
                none_left = 1'b0;
            end
        end
    end

endmodule

// File: rtl/dmem_byte_ctrl.sv
// Data-memory responder: takes a 32-bit byte-select request from the MEM
// stage and serializes it into byte accesses on an 8-bit external bus,
// stalling the pipeline until the last byte is done. Read bytes are
// returned in their original lane positions during a single DONE cycle.
// Optional build macro DMEM_SEL_CHK_EN rejects irregular select masks and
// adds the sticky sel_err_o flag.
module dmem_byte_ctrl
    import dmem_pkg::*;
#(
    parameter int EXT_AW      = 17,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    dmem_byte_ctrl_if.slave   bus,
    output logic [EXT_AW-1:0] ext_addr_o,
    output logic [7:0]        ext_wdata_o,
    input  logic [7:0]        ext_rdata_i,
    output logic              ext_en_o,
    output logic              ext_we_o
`ifdef DMEM_SEL_CHK_EN
    ,
    output logic              sel_err_o
`endif
);

    localparam int WCW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(WAIT_CYCLES);

    state_t              state;
    logic                cap_we;
    logic [EXT_AW-3:0]   cap_addr;
    logic [LANES-1:0]    cap_sel;
    logic [31:0]         cap_wdata;
    logic [31:0]         rdata;
    logic [WCW-1:0]      wait_cnt;
    logic [1:0]          lane;

    logic [LANES-1:0]    scan_sel;
    logic [1:0]          scan_lane;
    logic                scan_first;
    logic [1:0]          nxt_lane;
    logic                nxt_none;
    logic                sel_bad;
    logic                in_access;
    logic                unused_addr_bits;

    // Only the word-aligned part of the external address is captured; the
    // lane index supplies the low two bits.
    assign unused_addr_bits = ^{bus.mem_addr_i[31:EXT_AW], bus.mem_addr_i[1:0]};

    // In IDLE the scan looks at the incoming mask from lane 0 inclusive;
    // during ACCESS it steps through the captured mask above the current lane.
    assign scan_first = (state == ST_IDLE);
    assign scan_sel   = scan_first ? bus.mem_sel_i : cap_sel;
    assign scan_lane  = scan_first ? 2'd0 : lane;

    dmem_next_lane u_next_lane (
        .sel       (scan_sel),
        .lane      (scan_lane),
        .inclusive (scan_first),
        .next_lane (nxt_lane),
        .none_left (nxt_none)
    );

`ifdef DMEM_SEL_CHK_EN
    assign sel_bad = ~sel_is_legal(bus.mem_sel_i);
`else
    assign sel_bad = 1'b0;
`endif

    // Main sequencer: capture in IDLE, walk the selected lanes in ACCESS,
    // then present the result for exactly one DONE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cap_we    <= 1'b0;
            cap_addr  <= '0;
            cap_sel   <= '0;
            cap_wdata <= '0;
            rdata     <= '0;
            wait_cnt  <= '0;
            lane      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.mem_ce_i) begin
                        cap_we    <= bus.mem_we_i;
                        cap_addr  <= bus.mem_addr_i[EXT_AW-1:2];
                        cap_sel   <= bus.mem_sel_i;
                        cap_wdata <= bus.mem_data_i;
                        rdata     <= '0;
                        wait_cnt  <= '0;
                        if (sel_bad || nxt_none) begin
                            state <= ST_DONE;
                        end else begin
                            lane  <= nxt_lane;
                            state <= ST_ACCESS;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (wait_cnt == WAIT_LAST) begin
                        wait_cnt <= '0;
                        if (!cap_we) begin
                            rdata[lane*LANE_W +: LANE_W] <= ext_rdata_i;
                        end
                        if (nxt_none) begin
                            state <= ST_DONE;
                        end else begin
                            lane <= nxt_lane;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + WCW'(1);
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef DMEM_SEL_CHK_EN
    // Sticky flag recording that an irregular select mask was ever presented.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_err_o <= 1'b0;
        end else if (state == ST_IDLE && bus.mem_ce_i && sel_bad) begin
            sel_err_o <= 1'b1;
        end
    end
`endif

    // External bus is driven only while a byte access is in progress so that
    // every output rests at zero outside ACCESS.
    assign in_access   = (state == ST_ACCESS);
    assign ext_en_o    = in_access;
    assign ext_we_o    = in_access & cap_we;
    assign ext_addr_o  = in_access ? {cap_addr, lane} : '0;
    assign ext_wdata_o = in_access ? cap_wdata[lane*LANE_W +: LANE_W] : '0;

    // Pipeline side: stall until DONE; load data is visible only in DONE.
    assign bus.stall_o    = bus.mem_ce_i & (state != ST_DONE) & ~rst;
    assign bus.mem_data_o = ((state == ST_DONE) && !cap_we) ? rdata : '0;

endmodule
